// File: rtl/ntt_sbuf_pkg.sv
// Shared helpers for the NTT stride buffer: point permutation and bank selection.
package ntt_sbuf_pkg;

    // Rotate the low l bits of p right by rot (rot < 2*l).
    function automatic logic [31:0] perm_idx(input logic [31:0] p, input logic [31:0] rot,
                                             input int unsigned l);
        logic [31:0] r;
        logic [31:0] j;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            j = 32'(i) + rot;
            if (j >= l) j = j - l;
            if (j >= l) j = j - l;
            if (32'(i) < l) r[5'(i)] = p[j[4:0]];
        end
        return r;
    endfunction

    // Points whose indices differ in one bit always land in opposite banks.
    function automatic logic bank_of(input logic [31:0] p);
        return ^p;
    endfunction

endpackage

// File: rtl/ntt_skid_fifo.sv
// Two-entry FIFO with a registered head; absorbs RAM read data under output backpressure.
module ntt_skid_fifo #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop_ready,
    output logic         pop_valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] d0, d1;
    logic         v0, v1;
    logic         pop;

    assign pop       = v0 && pop_ready;
    assign pop_valid = v0;
    assign dout      = d0;
    assign count     = 2'(v0) + 2'(v1);

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            d0 <= '0;
            d1 <= '0;
        end else if (pop) begin
            if (v1) begin
                d0 <= d1;
                if (push) d1 <= din;
                else      v1 <= 1'b0;
            end else if (push) begin
                d0 <= din;
            end else begin
                v0 <= 1'b0;
            end
        end else if (push) begin
            if (!v0) begin
                d0 <= din;
                v0 <= 1'b1;
            end else begin
                d1 <= din;
                v1 <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/ram_1w1r_1clk.sv
// Simple dual-port RAM: one write and one registered read per cycle, single clock.
module ram_1w1r_1clk #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ntt_stride_buf.sv
// Double-buffered NTT stage permutation buffer with runtime rotate stride and valid/ready.
// Define NTT_SBUF_TWIDDLE_EN to carry twiddles through banked RAMs alongside the data.
module ntt_stride_buf
    import ntt_sbuf_pkg::*;
#(
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned DATA_W = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [$clog2($clog2(2*DEPTH))-1:0]   rot_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [1:0][DATA_W-1:0]               x_i,
    input  logic [1:0][DATA_W-1:0]               w_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [1:0][DATA_W-1:0]               x_o,
    output logic [1:0][DATA_W-1:0]               w_o,
    output logic                                 out_last_o
);
    localparam int unsigned LW = $clog2(2 * DEPTH);
    localparam int unsigned RW = $clog2(LW);
    localparam int unsigned CW = $clog2(DEPTH);
    localparam int unsigned AW = CW + 1;
    localparam int unsigned PW = 4 * DATA_W + 1;

    typedef logic [1:0][DATA_W-1:0] pair_t;

    logic [1:0]         wfrm, rfrm, wfrm_nxt, rfrm_nxt;
    logic [CW-1:0]      wcnt, rcnt;
    logic [1:0][RW-1:0] rot_q;
    logic               in_fire, out_fire, w_last, r_last, rd_issue;
    logic [1:0]         skid_cnt, occ_after;
    logic [RW-1:0]      rot_cur;
    logic [31:0]        q0, q1;
    logic               swap;
    logic               rd_pend, rd_last, rd_swap;
    logic [AW-1:0]      waddr;
    logic [1:0][AW-1:0] raddr;
    pair_t              xw, xr, x_push, w_push;
    logic [PW-1:0]      push_data, pop_data;

    // Handshakes, read issue gating and bank address/lane steering.
    always_comb begin
        in_fire   = in_valid_i && in_ready_o;
        out_fire  = out_valid_o && out_ready_i;
        w_last    = &wcnt;
        r_last    = &rcnt;
        occ_after = skid_cnt - 2'(out_fire);
        rd_issue  = (wfrm != rfrm) && ((occ_after + 2'(rd_pend)) < 2'd2);
        wfrm_nxt  = wfrm + 2'(in_fire && w_last);
        rfrm_nxt  = rfrm + 2'(rd_issue && r_last);

        waddr = {wfrm[0], wcnt};
        xw[0] = (^wcnt) ? x_i[1] : x_i[0];
        xw[1] = (^wcnt) ? x_i[0] : x_i[1];

        rot_cur  = rot_q[rfrm[0]];
        q0       = perm_idx(32'({rcnt, 1'b0}), 32'(rot_cur), LW);
        q1       = perm_idx(32'({rcnt, 1'b1}), 32'(rot_cur), LW);
        swap     = bank_of(q0);
        raddr[0] = {rfrm[0], swap ? CW'(q1 >> 1) : CW'(q0 >> 1)};
        raddr[1] = {rfrm[0], swap ? CW'(q0 >> 1) : CW'(q1 >> 1)};

        x_push[0] = rd_swap ? xr[1] : xr[0];
        x_push[1] = rd_swap ? xr[0] : xr[1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wfrm       <= '0;
            rfrm       <= '0;
            wcnt       <= '0;
            rcnt       <= '0;
            rot_q      <= '0;
            in_ready_o <= 1'b1;
            rd_pend    <= 1'b0;
            rd_last    <= 1'b0;
            rd_swap    <= 1'b0;
        end else begin
            wfrm       <= wfrm_nxt;
            rfrm       <= rfrm_nxt;
            in_ready_o <= (wfrm_nxt - rfrm_nxt) != 2'd2;
            if (in_fire) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == '0) rot_q[wfrm[0]] <= rot_i;
            end
            if (rd_issue) rcnt <= rcnt + 1'b1;
            rd_pend <= rd_issue;
            rd_last <= rd_issue && r_last;
            rd_swap <= swap;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_xbank
        ram_1w1r_1clk #(.DW(DATA_W), .AW(AW)) u_ram (
            .clk(clk_i), .we(in_fire), .waddr(waddr), .wdata(xw[b]),
            .re(rd_issue), .raddr(raddr[b]), .rdata(xr[b])
        );
    end

`ifdef NTT_SBUF_TWIDDLE_EN
    pair_t ww, wr;

    always_comb begin
        ww[0]     = (^wcnt) ? w_i[1] : w_i[0];
        ww[1]     = (^wcnt) ? w_i[0] : w_i[1];
        w_push[0] = rd_swap ? wr[1] : wr[0];
        w_push[1] = rd_swap ? wr[0] : wr[1];
    end

    for (genvar b = 0; b < 2; b++) begin : g_wbank
        ram_1w1r_1clk #(.DW(DATA_W), .AW(AW)) u_ram (
            .clk(clk_i), .we(in_fire), .waddr(waddr), .wdata(ww[b]),
            .re(rd_issue), .raddr(raddr[b]), .rdata(wr[b])
        );
    end
`else
    logic unused_w;
    assign unused_w = ^w_i;
    assign w_push   = '0;
`endif

    assign push_data = {x_push, w_push, rd_last};

    ntt_skid_fifo #(.W(PW)) u_skid (
        .clk(clk_i), .rst(rst_i), .push(rd_pend), .din(push_data),
        .pop_ready(out_ready_i), .pop_valid(out_valid_o), .dout(pop_data), .count(skid_cnt)
    );

    assign {x_o, w_o, out_last_o} = pop_data;
endmodule

// File: tb/tb_ntt_stride_buf.sv
// Self-checking bench for ntt_stride_buf (DEPTH=4); scoreboard built from the rotate-right rule.
module tb_ntt_stride_buf;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int T  = 2 * DEPTH;
    localparam int L  = 3;
    localparam int RW = 2;
`ifdef NTT_SBUF_TWIDDLE_EN
    localparam bit TW_EN = 1'b1;
`else
    localparam bit TW_EN = 1'b0;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [RW-1:0]           rot_i;
    logic                    in_valid_i, in_ready_o;
    logic [1:0][DATA_W-1:0]  x_i, w_i, x_o, w_o;
    logic                    out_valid_o, out_ready_i, out_last_o;

    always #5 clk_i = ~clk_i;

    ntt_stride_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .rot_i(rot_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .x_i(x_i), .w_i(w_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .x_o(x_o), .w_o(w_o), .out_last_o(out_last_o)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    logic [DATA_W-1:0] qx0[$], qx1[$], qw0[$], qw1[$];
    int                qrot[$];
    logic [DATA_W-1:0] ex0[$], ex1[$], ew0[$], ew1[$];
    bit                el[$];
    logic [DATA_W-1:0] fx[T], fw[T];
    int  fwords = 0, frot = 0;

    bit  send_en = 1'b0, rdy_rand = 1'b0, rdy_fix = 1'b1, in_gaps = 1'b0;
    bit  stalled = 1'b0;
    logic [1:0][DATA_W-1:0] px, pw;
    logic pl;
    int  accepted = 0, last_hs = 0, ready_drops = 0;
    int  first_out = -1, last_out = 0, n_out = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int perm(input int p, input int r);
        return ((p >> r) | (p << (L - r))) & (T - 1);
    endfunction

    task automatic model_push(input logic [DATA_W-1:0] a0, input logic [DATA_W-1:0] a1,
                              input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] b1,
                              input int r);
        int p0, p1;
        if (fwords == 0) frot = r;
        fx[L'(2 * fwords)]     = a0;
        fx[L'(2 * fwords + 1)] = a1;
        fw[L'(2 * fwords)]     = b0;
        fw[L'(2 * fwords + 1)] = b1;
        fwords++;
        if (fwords == DEPTH) begin
            for (int k = 0; k < DEPTH; k++) begin
                p0 = perm(2 * k, frot);
                p1 = perm(2 * k + 1, frot);
                ex0.push_back(fx[L'(p0)]);
                ex1.push_back(fx[L'(p1)]);
                ew0.push_back(TW_EN ? fw[L'(p0)] : '0);
                ew1.push_back(TW_EN ? fw[L'(p1)] : '0);
                el.push_back(k == DEPTH - 1);
            end
            fwords = 0;
        end
    endtask

    task automatic enqueue(input int r, input bit rnd);
        for (int w = 0; w < DEPTH; w++) begin
            qx0.push_back(rnd ? DATA_W'($urandom) : DATA_W'(2 * w));
            qx1.push_back(rnd ? DATA_W'($urandom) : DATA_W'(2 * w + 1));
            qw0.push_back(rnd ? DATA_W'($urandom) : DATA_W'(100 + 2 * w));
            qw1.push_back(rnd ? DATA_W'($urandom) : DATA_W'(101 + 2 * w));
            qrot.push_back(w == 0 ? r : int'($urandom_range(3)));
        end
    endtask

    task automatic step();
        bit take;
        @(negedge clk_i);
        cyc++;
        out_ready_i = rdy_rand ? ($urandom_range(99) < 70) : rdy_fix;
        if (stalled) begin
            chk("hold_valid", 64'(out_valid_o), 64'd1);
            chk("hold_x", 64'(x_o), 64'(px));
            chk("hold_w", 64'(w_o), 64'(pw));
            chk("hold_last", 64'(out_last_o), 64'(pl));
        end
        if (out_valid_o === 1'b1) begin
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            n_out++;
            if (out_ready_i) begin
                if (ex0.size() == 0) begin
                    chk("spurious_valid", 64'(out_valid_o), 64'd0);
                end else begin
                    chk("x_lane0", 64'(x_o[0]), 64'(ex0.pop_front()));
                    chk("x_lane1", 64'(x_o[1]), 64'(ex1.pop_front()));
                    chk("w_lane0", 64'(w_o[0]), 64'(ew0.pop_front()));
                    chk("w_lane1", 64'(w_o[1]), 64'(ew1.pop_front()));
                    chk("last", 64'(out_last_o), 64'(el.pop_front()));
                end
            end
        end
        stalled = (out_valid_o === 1'b1) && !out_ready_i;
        px = x_o;
        pw = w_o;
        pl = out_last_o;

        take = 1'b0;
        if (send_en && qx0.size() > 0 && !(in_gaps && $urandom_range(3) == 0)) begin
            in_valid_i = 1'b1;
            x_i = {qx1[0], qx0[0]};
            w_i = {qw1[0], qw0[0]};
            rot_i = RW'(qrot[0]);
            if (in_ready_o !== 1'b1) ready_drops++;
            else take = 1'b1;
        end else begin
            in_valid_i = 1'b0;
            x_i = {DATA_W'($urandom), DATA_W'($urandom)};
            w_i = {DATA_W'($urandom), DATA_W'($urandom)};
            rot_i = RW'($urandom);
        end
        if (take) begin
            model_push(qx0.pop_front(), qx1.pop_front(), qw0.pop_front(), qw1.pop_front(),
                       qrot.pop_front());
            accepted++;
            last_hs = cyc;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((qx0.size() > 0 || ex0.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", 64'(qx0.size() + ex0.size()), 64'd0);
        repeat (3) step();
    endtask

    task automatic clear_stats();
        first_out = -1;
        n_out = 0;
        ready_drops = 0;
        accepted = 0;
    endtask

    initial begin
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        x_i = '0;
        w_i = '0;
        rot_i = '0;
        repeat (3) step();
        rst_i = 1'b0;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_last", 64'(out_last_o), 64'd0);

        // identity frame, first-output latency
        clear_stats();
        send_en = 1'b1;
        enqueue(0, 1'b0);
        drain(60);
        chk("latency", 64'(first_out - last_hs), 64'd3);

        clear_stats();
        enqueue(1, 1'b0);
        drain(60);
        enqueue(2, 1'b0);
        drain(60);

        // three back-to-back frames
        clear_stats();
        enqueue(1, 1'b0);
        enqueue(2, 1'b0);
        enqueue(0, 1'b0);
        drain(100);
        chk("b2b_ready_drops", 64'(ready_drops), 64'd0);
        chk("b2b_out_words", 64'(n_out), 64'(3 * DEPTH));
        chk("b2b_contiguous", 64'(last_out - first_out + 1), 64'(n_out));

        // downstream stall fills both buffers
        clear_stats();
        rdy_fix = 1'b0;
        for (int f = 0; f < 3; f++) enqueue(int'($urandom_range(L - 1)), 1'b1);
        repeat (20) step();
        chk("stall_accepted", 64'(accepted), 64'(2 * DEPTH));
        chk("stall_in_ready", 64'(in_ready_o), 64'd0);
        chk("stall_out_valid", 64'(out_valid_o), 64'd1);
        rdy_fix = 1'b1;
        drain(100);

        // random traffic with gaps and backpressure
        rdy_rand = 1'b1;
        in_gaps = 1'b1;
        for (int f = 0; f < 8; f++) enqueue(int'($urandom_range(L - 1)), 1'b1);
        drain(2000);
        rdy_rand = 1'b0;
        in_gaps = 1'b0;

        // reset mid-frame discards the partial frame
        clear_stats();
        enqueue(2, 1'b0);
        for (int n = 0; n < 20 && accepted < 2; n++) step();
        send_en = 1'b0;
        step();
        rst_i = 1'b1;
        qx0.delete(); qx1.delete(); qw0.delete(); qw1.delete(); qrot.delete();
        fwords = 0;
        repeat (2) step();
        rst_i = 1'b0;
        chk("mid_rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid_o), 64'd0);
        repeat (6) begin
            step();
            chk("no_out_after_rst", 64'(out_valid_o), 64'd0);
        end
        send_en = 1'b1;
        enqueue(1, 1'b0);
        drain(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
